// File: rtl/window_ctrl.sv
// window_ctrl: owns CWP/WIM, executes SAVE/RESTORE and spills/fills a window through memory on overflow/underflow
//   Clk, Clr                 clock, synchronous active-high reset
//   save, restore            window requests, sampled only while idle
//   busy, done               spill/fill in progress; one-cycle pulse when new cwp/wim are visible
//   cwp, wim                 current window pointer, one-hot window invalid mask
//   rf_enable..rf_in, rf_out register-file port used only during spill/fill
//   mem_req..mem_ack         one memory transfer per register, {window, offset} addressed
module window_ctrl #(
    parameter int NWIN  = 4,
    parameter int CWP_W = 2
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             save,
    input  logic             restore,
    output logic             busy,
    output logic             done,
    output logic [CWP_W-1:0] cwp,
    output logic [NWIN-1:0]  wim,
    output logic             rf_enable,
    output logic             rf_rw,
    output logic [CWP_W-1:0] rf_window,
    output logic [4:0]       rf_rnum,
    output logic [31:0]      rf_in,
    input  logic [31:0]      rf_out,
    output logic             mem_req,
    output logic             mem_we,
    output logic [CWP_W+3:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SPILL_RD  = 3'd1;
    localparam logic [2:0] S_SPILL_CAP = 3'd2;
    localparam logic [2:0] S_SPILL_MEM = 3'd3;
    localparam logic [2:0] S_FILL_MEM  = 3'd4;
    localparam logic [2:0] S_FILL_WR   = 3'd5;
    localparam logic [2:0] S_COMMIT    = 3'd6;
    logic [2:0]       state_q, state_d;
    logic [CWP_W-1:0] cwp_q, cwp_d, tgt_q, tgt_d;
    logic [NWIN-1:0]  wim_q, wim_d;
    logic [3:0]       off_q, off_d;
    logic             fill_q, fill_d, done_q, done_d;
    logic [31:0]      wdata_q, wdata_d, rfin_q, rfin_d;
    logic [CWP_W-1:0] sv_new, rs_new, tgt_inc, tgt_dec;
    assign sv_new  = cwp_q - 1'b1;
    assign rs_new  = cwp_q + 1'b1;
    assign tgt_inc = tgt_q + 1'b1;
    assign tgt_dec = tgt_q - 1'b1;
    always_comb begin
        state_d = state_q;
        cwp_d   = cwp_q;
        wim_d   = wim_q;
        tgt_d   = tgt_q;
        off_d   = off_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        wdata_d = wdata_q;
        rfin_d  = rfin_q;
        case (state_q)
            S_IDLE: begin
                // Simultaneous save and restore cancel out and do nothing.
                if (save && !restore) begin
                    if (wim_q[sv_new]) begin
                        tgt_d   = sv_new;
                        off_d   = 4'd0;
                        fill_d  = 1'b0;
                        state_d = S_SPILL_RD;
                    end else begin
                        cwp_d  = sv_new;
                        done_d = 1'b1;
                    end
                end else if (restore && !save) begin
                    if (wim_q[rs_new]) begin
                        tgt_d   = rs_new;
                        off_d   = 4'd0;
                        fill_d  = 1'b1;
                        state_d = S_FILL_MEM;
                    end else begin
                        cwp_d  = rs_new;
                        done_d = 1'b1;
                    end
                end
            end
            S_SPILL_RD: state_d = S_SPILL_CAP;
            S_SPILL_CAP: begin
                // Register-file read data arrives one cycle after the strobe.
                wdata_d = rf_out;
                state_d = S_SPILL_MEM;
            end
            S_SPILL_MEM: begin
                if (mem_ack) begin
                    off_d   = off_q + 1'b1;
                    state_d = (off_q == 4'd15) ? S_COMMIT : S_SPILL_RD;
                end
            end
            S_FILL_MEM: begin
                if (mem_ack) begin
                    rfin_d  = mem_rdata;
                    state_d = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                off_d   = off_q + 1'b1;
                state_d = (off_q == 4'd15) ? S_COMMIT : S_FILL_MEM;
            end
            S_COMMIT: begin
                // The invalid window sits just past the committed one in the direction of travel.
                cwp_d   = tgt_q;
                wim_d   = NWIN'(1) << (fill_q ? tgt_inc : tgt_dec);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= S_IDLE;
            cwp_q   <= '0;
            wim_q   <= NWIN'(2);
            tgt_q   <= '0;
            off_q   <= '0;
            fill_q  <= 1'b0;
            done_q  <= 1'b0;
            wdata_q <= '0;
            rfin_q  <= '0;
        end else begin
            state_q <= state_d;
            cwp_q   <= cwp_d;
            wim_q   <= wim_d;
            tgt_q   <= tgt_d;
            off_q   <= off_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
            wdata_q <= wdata_d;
            rfin_q  <= rfin_d;
        end
    end
    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
    assign cwp       = cwp_q;
    assign wim       = wim_q;
    assign rf_enable = (state_q == S_SPILL_RD) || (state_q == S_FILL_WR);
    assign rf_rw     = state_q == S_FILL_WR;
    assign rf_window = busy ? tgt_q : '0;
    assign rf_rnum   = busy ? {1'b1, off_q} : 5'd0;
    assign rf_in     = rfin_q;
    assign mem_req   = (state_q == S_SPILL_MEM) || (state_q == S_FILL_MEM);
    assign mem_we    = state_q == S_SPILL_MEM;
    assign mem_addr  = busy ? {tgt_q, off_q} : '0;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_window_ctrl.sv
// tb_window_ctrl: directed bench for window_ctrl with register-file and memory models
module tb_window_ctrl;
    logic        Clk = 1'b0, Clr = 1'b1, save = 1'b0, restore = 1'b0;
    logic        busy, done, rf_enable, rf_rw, mem_req, mem_we;
    logic [1:0]  cwp, rf_window;
    logic [3:0]  wim;
    logic [4:0]  rf_rnum;
    logic [5:0]  mem_addr, h_addr;
    logic [31:0] rf_in, mem_wdata, h_wdata;
    logic [31:0] rf_out = '0, mem_rdata = '0, rd_val = '0;
    logic        mem_ack = 1'b0, rd_pend = 1'b0, preloaded = 1'b0;
    logic        auto_ack = 1'b1, force_ack = 1'b0;
    logic [31:0] rf_m [4][32];
    logic [31:0] wr_log [64];
    int nasserts = 0, fails = 0, wr_count = 0, rd_count = 0, wcnt = 0, ack_delay = 0;
    int hold_checks = 0, hold_viol = 0, idle_rf = 0;
    int n, hc0, wr6;

    window_ctrl dut (
        .Clk(Clk), .Clr(Clr), .save(save), .restore(restore), .busy(busy), .done(done),
        .cwp(cwp), .wim(wim), .rf_enable(rf_enable), .rf_rw(rf_rw), .rf_window(rf_window),
        .rf_rnum(rf_rnum), .rf_in(rf_in), .rf_out(rf_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 16; i++) begin
                rf_m[1][16+i] = 32'(100 + i);
                rf_m[2][16+i] = 32'(300 + i);
            end
            preloaded = 1'b1;
        end
        rf_out  = rd_pend ? rd_val : 32'h0;
        rd_pend = rf_enable && !rf_rw;
        rd_val  = rf_m[rf_window][rf_rnum];
        if (rf_enable && rf_rw) rf_m[rf_window][rf_rnum] = rf_in;
    end

    always @(negedge Clk) begin
        if (!auto_ack) begin
            mem_ack = force_ack;
            wcnt = 0;
        end else if (mem_req) begin
            if (wcnt == 0) begin
                h_addr  = mem_addr;
                h_wdata = mem_wdata;
            end else begin
                hold_checks++;
                if (mem_addr !== h_addr || mem_wdata !== h_wdata) hold_viol++;
            end
            if (wcnt == ack_delay) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (mem_we) begin
                    wr_log[mem_addr] = mem_wdata;
                    wr_count++;
                end else begin
                    mem_rdata = 32'(mem_addr) + 32'd184;
                    rd_count++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
        if (rf_enable && !busy) idle_rf++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic req(input logic s, input logic r);
        save = s;
        restore = r;
        step();
        save = 1'b0;
        restore = 1'b0;
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (!done && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_cwp"}, 64'(cwp), 64'd0);
        chk({p, "_wim"}, 64'(wim), 64'h2);
        chk({p, "_busy"}, 64'(busy), 64'd0);
        chk({p, "_done"}, 64'(done), 64'd0);
        chk({p, "_rf_enable"}, 64'(rf_enable), 64'd0);
        chk({p, "_rf_rw"}, 64'(rf_rw), 64'd0);
        chk({p, "_rf_window"}, 64'(rf_window), 64'd0);
        chk({p, "_rf_rnum"}, 64'(rf_rnum), 64'd0);
        chk({p, "_rf_in"}, 64'(rf_in), 64'd0);
        chk({p, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({p, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({p, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({p, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    initial begin
        step();
        step();
        Clr = 1'b0;
        chk_reset("rst");
        // plain save 0 -> 3
        req(1'b1, 1'b0);
        chk("save1_cwp", 64'(cwp), 64'd3);
        chk("save1_done", 64'(done), 64'd1);
        chk("save1_busy", 64'(busy), 64'd0);
        chk("save1_wim", 64'(wim), 64'h2);
        chk("save1_mem_req", 64'(mem_req), 64'd0);
        step();
        chk("save1_done_pulse", 64'(done), 64'd0);
        // 3 -> 2, then overflow into window 1
        req(1'b1, 1'b0);
        chk("save2_cwp", 64'(cwp), 64'd2);
        chk("save2_done", 64'(done), 64'd1);
        req(1'b1, 1'b0);
        chk("spill_busy", 64'(busy), 64'd1);
        chk("spill_rf_enable", 64'(rf_enable), 64'd1);
        chk("spill_rf_window", 64'(rf_window), 64'd1);
        chk("spill_rf_rnum", 64'(rf_rnum), 64'd16);
        wait_done(1, n);
        chk("spill_done_cycle", 64'(n), 64'd50);
        chk("spill_cwp", 64'(cwp), 64'd1);
        chk("spill_wim", 64'(wim), 64'h1);
        chk("spill_busy_end", 64'(busy), 64'd0);
        chk("spill_writes", 64'(wr_count), 64'd16);
        for (int i = 0; i < 16; i++) chk("spill_data", 64'(wr_log[{2'd1, 4'(i)}]), 64'(100 + i));
        // reset, then underflow fill of window 1
        Clr = 1'b1;
        step();
        Clr = 1'b0;
        chk("rst2_cwp", 64'(cwp), 64'd0);
        chk("rst2_wim", 64'(wim), 64'h2);
        req(1'b0, 1'b1);
        chk("fill_busy", 64'(busy), 64'd1);
        chk("fill_mem_req", 64'(mem_req), 64'd1);
        chk("fill_mem_we", 64'(mem_we), 64'd0);
        chk("fill_mem_addr", 64'(mem_addr), 64'd16);
        wait_done(1, n);
        chk("fill_done_cycle", 64'(n), 64'd34);
        for (int i = 0; i < 16; i++) chk("fill_rf", 64'(rf_m[1][16+i]), 64'(200 + i));
        chk("fill_cwp", 64'(cwp), 64'd1);
        chk("fill_wim", 64'(wim), 64'h4);
        chk("fill_reads", 64'(rd_count), 64'd16);
        // 1 -> 0 -> 3, then overflow into window 2 with slow memory
        req(1'b1, 1'b0);
        chk("save3_cwp", 64'(cwp), 64'd0);
        req(1'b1, 1'b0);
        chk("save4_cwp", 64'(cwp), 64'd3);
        ack_delay = 3;
        hc0 = hold_checks;
        req(1'b1, 1'b0);
        wait_done(1, n);
        chk("slow_done_cycle", 64'(n), 64'd98);
        chk("slow_cwp", 64'(cwp), 64'd2);
        chk("slow_wim", 64'(wim), 64'h2);
        chk("slow_writes", 64'(wr_count), 64'd32);
        chk("slow_hold_checks", 64'(hold_checks - hc0), 64'd48);
        chk("slow_hold_stable", 64'(hold_viol), 64'd0);
        for (int i = 0; i < 16; i++) chk("slow_data", 64'(wr_log[{2'd2, 4'(i)}]), 64'(300 + i));
        // save and restore together is a no-op
        ack_delay = 0;
        req(1'b1, 1'b1);
        chk("both_done", 64'(done), 64'd0);
        chk("both_busy", 64'(busy), 64'd0);
        chk("both_cwp", 64'(cwp), 64'd2);
        chk("both_wim", 64'(wim), 64'h2);
        step();
        chk("both_done2", 64'(done), 64'd0);
        // requests while busy are dropped
        req(1'b1, 1'b0);
        n = 1;
        save = 1'b1;
        repeat (10) begin
            step();
            n++;
        end
        save = 1'b0;
        restore = 1'b1;
        repeat (10) begin
            step();
            n++;
        end
        restore = 1'b0;
        chk("drop_busy", 64'(busy), 64'd1);
        chk("drop_done", 64'(done), 64'd0);
        wait_done(n, n);
        chk("drop_done_cycle", 64'(n), 64'd50);
        chk("drop_cwp", 64'(cwp), 64'd1);
        chk("drop_wim", 64'(wim), 64'h1);
        chk("drop_writes", 64'(wr_count), 64'd48);
        step();
        chk("drop_done2", 64'(done), 64'd0);
        chk("drop_cwp2", 64'(cwp), 64'd1);
        chk("drop_busy2", 64'(busy), 64'd0);
        // Clr in the middle of a spill, then a stray ack
        ack_delay = 3;
        wr6 = wr_count;
        req(1'b1, 1'b0);
        n = 1;
        while (!(mem_req && mem_addr == 6'd7) && n < 500) begin
            step();
            n++;
        end
        chk("abort_req", 64'(mem_req), 64'd1);
        chk("abort_addr", 64'(mem_addr), 64'd7);
        auto_ack = 1'b0;
        Clr = 1'b1;
        step();
        Clr = 1'b0;
        chk_reset("abort");
        chk("abort_writes", 64'(wr_count), 64'(wr6 + 7));
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        step();
        chk("late_ack_busy", 64'(busy), 64'd0);
        chk("late_ack_cwp", 64'(cwp), 64'd0);
        chk("late_ack_wim", 64'(wim), 64'h2);
        chk("late_ack_done", 64'(done), 64'd0);
        chk("late_ack_mem_req", 64'(mem_req), 64'd0);
        chk("late_ack_rf_enable", 64'(rf_enable), 64'd0);
        chk("idle_rf_enable", 64'(idle_rf), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, fails);
        $finish;
    end
endmodule
